// File: rtl/weight_pkg.sv
// Shared types and layout helpers for the kernel weight tap loader.
// Offsets are in bits; (i,j) is PE row / mesh column, k is the tap index.
package weight_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    function automatic int tap_width(input int ktaps);
        return $clog2(ktaps + 1);
    endfunction

    function automatic int ram_offset(input int i, input int j, input int x_mesh, input int w);
        return (j + i * x_mesh) * w;
    endfunction

    function automatic int ker_offset(input int k, input int i, input int j,
                                      input int ktaps, input int x_mesh, input int w);
        return (k + j * ktaps + i * ktaps * x_mesh) * w;
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// One weight bank: simple dual-port RAM, read-first, RD_LAT registered read stages.
// Contents are deliberately not reset so the array maps onto block RAM.
module weight_bank_ram #(
    parameter int DATA_LEN = 64,
    parameter int ADDR_LEN = 10,
    parameter int RD_LAT   = 2
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_LEN-1:0] wr_addr,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_LEN-1:0] rd_addr,
    output logic [DATA_LEN-1:0] rd_data
);

    logic [DATA_LEN-1:0] mem [2**ADDR_LEN];
    logic [DATA_LEN-1:0] pipe_reg [RD_LAT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of mem alongside the write gives old data on an address clash.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            pipe_reg[0] <= mem[rd_addr];
        end
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_reg[k] <= pipe_reg[k-1];
        end
    end

    assign rd_data = pipe_reg[RD_LAT-1];

endmodule

// File: rtl/weight_tap_loader.sv
// Loads 1..KTAPS_MAX consecutive RAM words into a staging kernel and hands it
// to the PE array through a valid/ready register, overlapping the next load.
module weight_tap_loader
    import weight_pkg::*;
#(
    parameter int X_PE         = 16,
    parameter int X_MESH       = 16,
    parameter int W            = 8,
    parameter int KTAPS_MAX    = 9,
    parameter int DATA_LEN     = 64,
    parameter int DDR_DATA_LEN = 256,
    parameter int ADDR_LEN     = 10,
    parameter int RD_LAT       = 2,
    parameter int BANKS        = (X_PE * X_MESH * W) / DATA_LEN,
    parameter int TW           = tap_width(KTAPS_MAX)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DDR_DATA_LEN-1:0]           wr_data,
    input  logic [ADDR_LEN-1:0]               wr_addr,
    input  logic [BANKS-1:0]                  wr_en,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [ADDR_LEN-1:0]               cfg_addr,
    input  logic [TW-1:0]                     cfg_taps,
    output logic                              cfg_err,
    output logic [X_PE*X_MESH*KTAPS_MAX*W-1:0] ker_out,
    output logic                              ker_valid,
    input  logic                              ker_ready,
    output logic                              idle
);

    localparam int WORD = X_PE * X_MESH * W;
    localparam int KW   = WORD * KTAPS_MAX;
    localparam logic [TW-1:0] KT = TW'(KTAPS_MAX);

    state_t              state_reg, state_next;
    logic [ADDR_LEN-1:0] rd_addr_reg, rd_addr_next;
    logic [TW-1:0]       issue_idx_reg, issue_idx_next;
    logic [TW-1:0]       taps_reg, taps_next;
    logic                rd_en, accept, err_next, do_commit;

    logic                tag_valid_reg [RD_LAT];
    logic [TW-1:0]       tag_idx_reg [RD_LAT];
    logic                land, last_land;
    logic [TW-1:0]       land_idx;

    logic [KW-1:0]       staging_reg, ker_out_reg;
    logic                ker_valid_reg, cfg_err_reg;

    logic [DDR_DATA_LEN-1:0] wr_data_reg;
    logic [ADDR_LEN-1:0]     wr_addr_reg;
    logic [BANKS-1:0]        wr_en_reg;
    logic [WORD-1:0]         rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_reg <= '0;
        end else begin
            wr_en_reg <= wr_en;
        end
        wr_data_reg <= wr_data;
        wr_addr_reg <= wr_addr;
    end

    // The RAM samples the next-state address so the tap read starts on the issuing edge.
    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            localparam int GOFF = (gi * DATA_LEN) % DDR_DATA_LEN;
            weight_bank_ram #(
                .DATA_LEN(DATA_LEN),
                .ADDR_LEN(ADDR_LEN),
                .RD_LAT  (RD_LAT)
            ) u_ram (
                .clk    (clk),
                .wr_en  (wr_en_reg[gi]),
                .wr_addr(wr_addr_reg),
                .wr_data(wr_data_reg[GOFF +: DATA_LEN]),
                .rd_en  (rd_en),
                .rd_addr(rd_addr_next),
                .rd_data(rd_word[gi*DATA_LEN +: DATA_LEN])
            );
        end
    endgenerate

    assign land      = tag_valid_reg[RD_LAT-1];
    assign land_idx  = tag_idx_reg[RD_LAT-1];
    assign last_land = land && (land_idx == taps_reg - TW'(1));

    always_comb begin
        state_next     = state_reg;
        rd_addr_next   = rd_addr_reg;
        issue_idx_next = issue_idx_reg;
        taps_next      = taps_reg;
        rd_en          = 1'b0;
        accept         = 1'b0;
        err_next       = 1'b0;
        do_commit      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cfg_valid) begin
                    if (cfg_taps != '0 && cfg_taps <= KT) begin
                        accept         = 1'b1;
                        taps_next      = cfg_taps;
                        rd_addr_next   = cfg_addr;
                        issue_idx_next = '0;
                        rd_en          = 1'b1;
                        state_next     = ISSUE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (issue_idx_reg + TW'(1) < taps_reg) begin
                    rd_addr_next   = rd_addr_reg + ADDR_LEN'(1);
                    issue_idx_next = issue_idx_reg + TW'(1);
                    rd_en          = 1'b1;
                end else begin
                    // With a one-cycle RAM a single tap can already be landing here.
                    state_next = last_land ? COMMIT : DRAIN;
                end
            end
            DRAIN: begin
                if (last_land) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (!ker_valid_reg || ker_ready) begin
                    do_commit  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_valid_reg[k] <= 1'b0;
                tag_idx_reg[k]   <= '0;
            end
        end else begin
            tag_valid_reg[0] <= rd_en;
            tag_idx_reg[0]   <= issue_idx_next;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_idx_reg[k]   <= tag_idx_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rd_addr_reg   <= '0;
            issue_idx_reg <= '0;
            taps_reg      <= '0;
            staging_reg   <= '0;
            ker_out_reg   <= '0;
            ker_valid_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_addr_reg   <= rd_addr_next;
            issue_idx_reg <= issue_idx_next;
            taps_reg      <= taps_next;
            cfg_err_reg   <= err_next;
            if (accept) begin
                staging_reg <= '0;
            end else if (land) begin
                for (int i = 0; i < X_PE; i++) begin
                    for (int j = 0; j < X_MESH; j++) begin
                        staging_reg[ker_offset(int'(land_idx), i, j, KTAPS_MAX, X_MESH, W) +: W]
                            <= rd_word[ram_offset(i, j, X_MESH, W) +: W];
                    end
                end
            end
            if (do_commit) begin
                ker_out_reg   <= staging_reg;
                ker_valid_reg <= 1'b1;
            end else if (ker_valid_reg && ker_ready) begin
                ker_valid_reg <= 1'b0;
            end
        end
    end

    assign cfg_ready = (state_reg == IDLE);
    assign idle      = (state_reg == IDLE);
    assign cfg_err   = cfg_err_reg;
    assign ker_out   = ker_out_reg;
    assign ker_valid = ker_valid_reg;

endmodule

// File: tb/tb_weight_tap_loader.sv
// Randomised scoreboard bench for weight_tap_loader: expected kernels are built
// from a whole-word memory model and checked by a monitor on each handshake.
module tb_weight_tap_loader;

    localparam int X_PE         = 16;
    localparam int X_MESH       = 16;
    localparam int W            = 8;
    localparam int KTAPS_MAX    = 9;
    localparam int DATA_LEN     = 64;
    localparam int DDR_DATA_LEN = 256;
    localparam int ADDR_LEN     = 10;
    localparam int RD_LAT       = 2;
    localparam int WORD         = X_PE * X_MESH * W;
    localparam int BANKS        = WORD / DATA_LEN;
    localparam int TW           = $clog2(KTAPS_MAX + 1);
    localparam int KW           = WORD * KTAPS_MAX;
    localparam int DEPTH        = 1 << ADDR_LEN;

    logic                    clk;
    logic                    rst;
    logic [DDR_DATA_LEN-1:0] wr_data;
    logic [ADDR_LEN-1:0]     wr_addr;
    logic [BANKS-1:0]        wr_en;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [ADDR_LEN-1:0]     cfg_addr;
    logic [TW-1:0]           cfg_taps;
    logic                    cfg_err;
    logic [KW-1:0]           ker_out;
    logic                    ker_valid;
    logic                    ker_ready;
    logic                    idle;

    weight_tap_loader #(
        .X_PE(X_PE), .X_MESH(X_MESH), .W(W), .KTAPS_MAX(KTAPS_MAX),
        .DATA_LEN(DATA_LEN), .DDR_DATA_LEN(DDR_DATA_LEN),
        .ADDR_LEN(ADDR_LEN), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_taps(cfg_taps), .cfg_err(cfg_err),
        .ker_out(ker_out), .ker_valid(ker_valid), .ker_ready(ker_ready),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [WORD-1:0] mem_model [DEPTH];
    logic [KW-1:0]   exp_q [$];
    bit              rand_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_ker(input string name, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        int off;
        bit found;
        vectors++;
        if (got !== exp) begin
            miscompares++;
            found = 0;
            for (int i = 0; i < X_PE && !found; i++)
                for (int j = 0; j < X_MESH && !found; j++)
                    for (int k = 0; k < KTAPS_MAX && !found; k++) begin
                        off = (k + j * KTAPS_MAX + i * KTAPS_MAX * X_MESH) * W;
                        if (got[off +: W] !== exp[off +: W]) begin
                            found = 1;
                            $display("FAIL %s: pe %0d mesh %0d tap %0d got %02h expected %02h",
                                     name, i, j, k, got[off +: W], exp[off +: W]);
                        end
                    end
        end
    endtask

    // Reference kernel: tap k of (i,j) is byte (i,j) of word (addr+k) mod depth; unused taps are zero.
    function automatic logic [KW-1:0] expect_ker(input int addr, input int taps);
        logic [KW-1:0] e;
        int a;
        e = '0;
        for (int k = 0; k < taps; k++) begin
            a = (addr + k) % DEPTH;
            for (int i = 0; i < X_PE; i++)
                for (int j = 0; j < X_MESH; j++)
                    e[(k + j * KTAPS_MAX + i * KTAPS_MAX * X_MESH) * W +: W] =
                        mem_model[a][(j + i * X_MESH) * W +: W];
        end
        return e;
    endfunction

    function automatic logic [DDR_DATA_LEN-1:0] rand_bus();
        logic [DDR_DATA_LEN-1:0] r;
        for (int q = 0; q < DDR_DATA_LEN / 32; q++) r[q*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic wr(input int addr, input logic [DDR_DATA_LEN-1:0] data, input logic [BANKS-1:0] en);
        logic [WORD-1:0] word;
        for (int g = 0; g < WORD / DDR_DATA_LEN; g++) word[g*DDR_DATA_LEN +: DDR_DATA_LEN] = data;
        for (int b = 0; b < BANKS; b++)
            if (en[b]) mem_model[addr][b*DATA_LEN +: DATA_LEN] = word[b*DATA_LEN +: DATA_LEN];
        wr_data = data;
        wr_addr = ADDR_LEN'(addr);
        wr_en   = en;
        tick();
        wr_en   = '0;
    endtask

    task automatic do_load(input int addr, input int taps, input bit check_lat);
        int n;
        bit legal;
        n = 0;
        while (!cfg_ready && n < 100) begin
            tick();
            n++;
        end
        chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        legal = (taps >= 1 && taps <= KTAPS_MAX);
        cfg_valid = 1'b1;
        cfg_addr  = ADDR_LEN'(addr);
        cfg_taps  = TW'(taps);
        if (legal) exp_q.push_back(expect_ker(addr, taps));
        tick();
        cfg_valid = 1'b0;
        $display("load addr=%0d taps=%0d legal=%0d", addr, taps, legal);
        if (!legal) begin
            chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
            chk("cfg_ready_after_err", 32'(cfg_ready), 32'd1);
            tick();
            chk("cfg_err_clear", 32'(cfg_err), 32'd0);
        end else if (check_lat) begin
            n = 1;
            while (!ker_valid && n < 40) begin
                tick();
                n++;
            end
            chk("latency", n, taps + RD_LAT + 1);
        end
    endtask

    task automatic drain_queue();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: compare on every handshake; a held kernel must not move.
    logic          hold_prev = 1'b0;
    logic [KW-1:0] held_val;
    logic [KW-1:0] mon_exp;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) chk_ker("hold_stable", ker_out, held_val);
            if (ker_valid && ker_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_kernel: got a kernel, expected none pending");
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk_ker("kernel", ker_out, mon_exp);
                    $display("kernel handshake checked, %0d still queued", exp_q.size());
                end
            end
            hold_prev = ker_valid && !ker_ready;
            held_val  = ker_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DDR_DATA_LEN-1:0] d;
        rst = 1'b1; wr_data = '0; wr_addr = '0; wr_en = '0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_taps = '0; ker_ready = 1'b0;
        rand_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ker_valid", 32'(ker_valid), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk_ker("rst_ker_out", ker_out, '0);

        // Addresses 0..8 hold their own index in every byte; the rest random.
        for (int a = 0; a < 64; a++) begin
            for (int q = 0; q < DDR_DATA_LEN / W; q++) d[q*W +: W] = W'(a);
            wr(a, (a < 9) ? d : rand_bus(), '1);
        end
        repeat (3) tick();

        ker_ready = 1'b1;
        do_load(0, 9, 1);
        repeat (3) tick();

        for (int a = 100; a < 104; a++) wr(a, rand_bus(), '1);
        repeat (3) tick();
        do_load(100, 4, 1);
        repeat (3) tick();

        wr(1022, rand_bus(), '1);
        wr(1023, rand_bus(), '1);
        wr(0, rand_bus(), '1);
        wr(1, rand_bus(), '1);
        repeat (3) tick();
        do_load(1022, 4, 1);
        repeat (3) tick();
        drain_queue();

        do_load(0, 0, 0);
        do_load(5, 10, 0);
        repeat (15) tick();
        chk("illegal_no_valid", 32'(ker_valid), 32'd0);

        // Partial-bank overwrites, then random loads under random backpressure.
        for (int n = 0; n < 30; n++) wr($urandom_range(9, 63), rand_bus(), BANKS'($urandom));
        repeat (3) tick();
        fork
            begin
                for (int n = 0; n < 24; n++) do_load($urandom_range(0, 54), $urandom_range(0, 11), 0);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    ker_ready = 1'($urandom);
                    tick();
                end
            end
        join
        ker_ready = 1'b1;
        drain_queue();

        // Backpressure: first kernel held, second parks in COMMIT.
        ker_ready = 1'b0;
        do_load(10, 5, 0);
        do_load(20, 7, 0);
        repeat (20) tick();
        chk("park_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("park_idle", 32'(idle), 32'd0);
        chk("park_ker_valid", 32'(ker_valid), 32'd1);
        ker_ready = 1'b1;
        tick();
        ker_ready = 1'b0;
        chk("swap_ker_valid", 32'(ker_valid), 32'd1);
        chk("swap_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("swap_idle", 32'(idle), 32'd1);
        repeat (3) tick();
        ker_ready = 1'b1;
        drain_queue();

        // Reset in the middle of a 9-tap load.
        cfg_valid = 1'b1; cfg_addr = '0; cfg_taps = TW'(9);
        tick();
        cfg_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ker_valid", 32'(ker_valid), 32'd0);
        chk("abort_idle", 32'(idle), 32'd1);
        chk_ker("abort_ker_out", ker_out, '0);
        repeat (15) tick();
        chk("abort_no_valid", 32'(ker_valid), 32'd0);
        do_load(3, 9, 1);
        drain_queue();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
